// File: rtl/mipi_pkg.sv
// Shared CSI-2 definitions for the mipi_clk-domain pixel path.
//   - CSI-2 long-packet data type codes
//   - byte typedef used for payload buses
//   - RAW10 group geometry (5 bytes carry 4 pixels)
//   - packet-tracking state encoding
package mipi_pkg;

  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;

  localparam int unsigned RAW10_GROUP_BYTES = 5;
  localparam int unsigned PIXELS_PER_GROUP  = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/raw10_unpacker_if.sv
// Stream interface between the CSI-2 packet receiver and the RAW10 unpacker.
//   image_data[0:3]    payload bytes, [0] earliest
//   image_data_type    data type of the current long packet
//   image_data_enable  payload beat valid, high for the whole packet
//   frame_start/end    FS/FE short-packet pulses
//   pixel[0:3]         unpacked pixels, [0] leftmost
//   pixel_enable       pixel beat valid
//   pixel_x/pixel_y    coordinates of pixel[0]
//   line_done          pulse after a RAW10 line ends
//   frame_done         registered copy of frame_end
//   length_err         sticky: RAW10 packet ended with leftover bytes
// master: receiver side (drives payload, observes pixels)
// slave : unpacker side
interface raw10_unpacker_if
  import mipi_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 10,
  parameter int unsigned COORD_WIDTH = 12
);

  byte_t [0:3]                                 image_data;
  logic [5:0]                                  image_data_type;
  logic                                        image_data_enable;
  logic                                        frame_start;
  logic                                        frame_end;

  logic [0:PIXELS_PER_GROUP-1][PIXEL_WIDTH-1:0] pixel;
  logic                                        pixel_enable;
  logic [COORD_WIDTH-1:0]                      pixel_x;
  logic [COORD_WIDTH-1:0]                      pixel_y;
  logic                                        line_done;
  logic                                        frame_done;
  logic                                        length_err;

  modport master (
    output image_data, image_data_type, image_data_enable, frame_start, frame_end,
    input  pixel, pixel_enable, pixel_x, pixel_y, line_done, frame_done, length_err
  );

  modport slave (
    input  image_data, image_data_type, image_data_enable, frame_start, frame_end,
    output pixel, pixel_enable, pixel_x, pixel_y, line_done, frame_done, length_err
  );

endinterface

// File: rtl/raw10_gearbox.sv
// 4-to-5 byte gearbox for RAW10 payload.
//   clk_i, rst_n_i  clock, async active-low reset
//   clear_i         drop any residue (packet end)
//   accept_i        data_i carries 4 new payload bytes
//   data_i[0:3]     payload bytes, [0] earliest
//   group_o[0:4]    completed 5-byte group (valid with valid_o)
//   valid_o         combinational: this accepted beat completes a group
//   count_o         bytes currently held as residue (0..4 between beats)
module raw10_gearbox
  import mipi_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              clear_i,
  input  logic                              accept_i,
  input  byte_t [0:3]                       data_i,
  output byte_t [0:RAW10_GROUP_BYTES-1]     group_o,
  output logic                              valid_o,
  output logic [3:0]                        count_o
);

  byte_t [0:7] buf_q, buf_d, merged;
  logic  [3:0] cnt_q, cnt_d, total;
  logic  [2:0] base;

  always_comb begin
    // New bytes land directly after the residue; residue never exceeds 4,
    // so the merged view always fits in 8 bytes.
    merged = buf_q;
    base   = cnt_q[2:0];
    for (int unsigned i = 0; i < 4; i++) begin
      merged[base + 3'(i)] = data_i[i];
    end
    total   = cnt_q + 4'd4;
    valid_o = accept_i && (total >= 4'(RAW10_GROUP_BYTES));
    group_o = merged[0:RAW10_GROUP_BYTES-1];

    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (accept_i) begin
      if (valid_o) begin
        buf_d = '0;
        for (int unsigned j = 0; j < 3; j++) begin
          buf_d[j] = merged[j + RAW10_GROUP_BYTES];
        end
        cnt_d = total - 4'(RAW10_GROUP_BYTES);
      end else begin
        buf_d = merged;
        cnt_d = total;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/raw10_unpacker.sv
// RAW10 unpacker: filters RAW10 long packets, regroups payload through the
// gearbox and emits 4 pixels per beat with x/y position and line/frame marks.
//   mipi_clk  byte clock of the CSI-2 receiver
//   reset_n   asynchronous active-low reset
//   bus       slave side of raw10_unpacker_if (payload in, pixels out)
module raw10_unpacker
  import mipi_pkg::*;
#(
  parameter logic [5:0]  DATA_TYPE_RAW10 = DT_RAW10,
  parameter int unsigned PIXEL_WIDTH     = 10,
  parameter int unsigned COORD_WIDTH     = 12
)(
  input  logic            mipi_clk,
  input  logic            reset_n,
  raw10_unpacker_if.slave bus
);

  pkt_state_e state_q, state_d;

  logic [0:PIXELS_PER_GROUP-1][PIXEL_WIDTH-1:0] pixel_q, pixel_d, unpacked;
  logic                   pixel_en_q, pixel_en_d;
  logic [COORD_WIDTH-1:0] pixel_x_q, pixel_x_d;
  logic [COORD_WIDTH-1:0] x_cnt_q, x_cnt_d;
  logic [COORD_WIDTH-1:0] pixel_y_q, pixel_y_d;
  logic                   line_done_q, line_done_d;
  logic                   frame_done_q, frame_done_d;
  logic                   length_err_q, length_err_d;

  logic                   accept, pkt_end;
  byte_t [0:RAW10_GROUP_BYTES-1] group;
  logic                   group_valid;
  logic [3:0]             residue;

  assign accept  = bus.image_data_enable && (bus.image_data_type == DATA_TYPE_RAW10);
  assign pkt_end = (state_q == IN_PACKET) && !bus.image_data_enable;

  raw10_gearbox u_gearbox (
    .clk_i    (mipi_clk),
    .rst_n_i  (reset_n),
    .clear_i  (pkt_end),
    .accept_i (accept),
    .data_i   (bus.image_data),
    .group_o  (group),
    .valid_o  (group_valid),
    .count_o  (residue)
  );

  // Byte 4 of a group carries the two LSBs of each pixel, pixel 0 lowest.
  if (PIXEL_WIDTH == 8) begin : g_pw8
    always_comb begin
      for (int unsigned i = 0; i < PIXELS_PER_GROUP; i++) begin
        unpacked[i] = group[i];
      end
    end
  end else begin : g_pw10
    always_comb begin
      for (int unsigned i = 0; i < PIXELS_PER_GROUP; i++) begin
        unpacked[i] = {group[i], group[PIXELS_PER_GROUP][2*i +: 2]};
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pixel_d      = pixel_q;
    pixel_en_d   = 1'b0;
    pixel_x_d    = pixel_x_q;
    x_cnt_d      = x_cnt_q;
    pixel_y_d    = pixel_y_q;
    line_done_d  = 1'b0;
    frame_done_d = bus.frame_end;
    length_err_d = length_err_q;

    unique case (state_q)
      IDLE:      if (accept) state_d = IN_PACKET;
      IN_PACKET: if (!bus.image_data_enable) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (group_valid) begin
      pixel_d    = unpacked;
      pixel_en_d = 1'b1;
      pixel_x_d  = x_cnt_q;
      x_cnt_d    = x_cnt_q + COORD_WIDTH'(PIXELS_PER_GROUP);
    end

    if (pkt_end) begin
      line_done_d = 1'b1;
      pixel_y_d   = pixel_y_q + COORD_WIDTH'(1);
      pixel_x_d   = '0;
      x_cnt_d     = '0;
      if (residue != 4'd0) length_err_d = 1'b1;
    end

    // frame_start overrides a coincident packet end.
    if (bus.frame_start) begin
      pixel_y_d    = '0;
      pixel_x_d    = '0;
      x_cnt_d      = '0;
      length_err_d = 1'b0;
    end
  end

  always_ff @(posedge mipi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pixel_q      <= '0;
      pixel_en_q   <= 1'b0;
      pixel_x_q    <= '0;
      x_cnt_q      <= '0;
      pixel_y_q    <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      length_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pixel_q      <= pixel_d;
      pixel_en_q   <= pixel_en_d;
      pixel_x_q    <= pixel_x_d;
      x_cnt_q      <= x_cnt_d;
      pixel_y_q    <= pixel_y_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      length_err_q <= length_err_d;
    end
  end

  assign bus.pixel        = pixel_q;
  assign bus.pixel_enable = pixel_en_q;
  assign bus.pixel_x      = pixel_x_q;
  assign bus.pixel_y      = pixel_y_q;
  assign bus.line_done    = line_done_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.length_err   = length_err_q;

endmodule

// File: doc/raw10_unpacker.md
Name: raw10_unpacker

Overview:
Sits directly downstream of the CSI-2 `camera` packet receiver, in the mipi_clk domain, and feeds the frame-buffer arbiter.
- Takes the 4-byte-per-beat long-packet payload from the 2-lane receiver.
- Filters for RAW10 packets and unpacks the 5-byte RAW10 groups through a 4→5 byte gearbox.
- Emits 4 pixels per output beat, tagged with x/y position and line/frame markers.

Parameters:
- DATA_TYPE_RAW10, 6'h2B, CSI-2 data type accepted; all other long packets are ignored.
- PIXEL_WIDTH, 10, output pixel width. Must be 8 or 10. When 8, only the MSB byte is output and the LSBs are dropped.
- COORD_WIDTH, 12, width of the pixel_x and pixel_y counters.

Ports:
- mipi_clk, input, 1, byte clock of the CSI-2 receiver.
- reset_n, input, 1, asynchronous active-low reset.
- image_data, input, 4x8 ([0:3]), payload bytes; [0] is the earliest byte.
- image_data_type, input, 6, data type of the current long packet; valid while image_data_enable=1.
- image_data_enable, input, 1, payload beat valid. Stays high for the whole packet; its falling edge marks packet end.
- frame_start, input, 1, one-cycle FS short-packet pulse.
- frame_end, input, 1, one-cycle FE short-packet pulse.
- pixel, output, 4xPIXEL_WIDTH ([0:3]), unpacked pixels; [0] is leftmost.
- pixel_enable, output, 1, pixel beat valid.
- pixel_x, output, COORD_WIDTH, x coordinate of pixel[0].
- pixel_y, output, COORD_WIDTH, line index within the frame.
- line_done, output, 1, one-cycle pulse after the last beat of a RAW10 line.
- frame_done, output, 1, one-cycle pulse, registered copy of frame_end.
- length_err, output, 1, sticky flag: a RAW10 packet ended with leftover bytes. Cleared by frame_start.

Behaviour:
- Reset: every output and internal register goes to 0. This covers the byte buffer, count, counters, flags and the `in_packet` state.
- Accept condition: a beat is accepted when image_data_enable=1 and image_data_type==DATA_TYPE_RAW10. Beats of any other type are not buffered and change no state.
- Gearbox buffer:
  - 8-byte buffer plus a 4-bit byte count, range 0..8.
  - Each accepted beat appends 4 bytes after the current residue.
  - If the resulting count is ≥5, the first 5 bytes form a group and the remaining (count−5) bytes shift to the front.
  - The count sequence per 5 beats is 4→3→2→1→0, producing 4 groups.
  - The count never exceeds 8.
- Unpacking (group bytes B0..B4):
  - pixel[i] = {Bi, B4[2i+1:2i]}, for i = 0..3.
  - When PIXEL_WIDTH=8, pixel[i] = Bi.
- Latency: registered output. pixel_enable=1 in the cycle after the accepted beat that completes a group. pixel holds its value when pixel_enable=0.
- pixel_x: 0 for the first group of a line; +4 after each emitted group.
- States: IDLE and IN_PACKET.
  - IDLE→IN_PACKET on the first accepted beat.
  - IN_PACKET→IDLE on the first cycle with image_data_enable=0.
- Packet end (IN_PACKET→IDLE transition):
  - line_done pulses in that cycle.
  - pixel_y increments, wrapping at 2^COORD_WIDTH.
  - pixel_x resets to 0.
  - Byte count resets to 0.
  - A nonzero residue is discarded and sets length_err.
- frame_start: pixel_y←0, pixel_x←0, length_err←0. If frame_start coincides with a packet end, frame_start wins and pixel_y=0.
- frame_end: frame_done=1 in the next cycle. No other state changes.
- Back-to-back packets: a packet end followed by the next packet's first beat in the next cycle is legal. That beat starts with count 0.
- Reset mid-packet: everything clears asynchronously. After release, the remainder of the packet is still accepted, but pixel_x restarts at 0. No error is reported.

Decomposition:
- Shared package `mipi_pkg`:
  - CSI-2 data type constants (RAW8 6'h2A, RAW10 6'h2B, RAW12 6'h2C).
  - Byte typedef.
  - RAW10_GROUP_BYTES=5 and PIXELS_PER_GROUP=4.
- One sub-module, `raw10_gearbox`: the 8-byte buffer, count and group extraction, with a valid-out signal.
- Top level: unpacking, state machine, counters and flags.

Test Plan:
1. Single group. Reset, then RAW10 beats {11,22,33,44} and {E4,55,66,77}. Expect:
   - pixel_enable exactly 1 cycle after beat 2.
   - pixel = {044, 089, 0CE, 113}, pixel_x=0.
   - On packet end: length_err=1 (3 bytes left) and line_done pulses.
2. Full 640-pixel line: 200 beats. Expect:
   - 160 pixel_enable pulses in a 4-of-5 cadence.
   - Last pixel_x=636.
   - line_done once, pixel_y 0→1, length_err=0.
3. Non-RAW10 packet: 10 beats with type 6'h2A between RAW10 lines. Expect zero pixel_enable, pixel_y unchanged, line_done not asserted.
4. frame_start coincident with packet end after line 5. Expect pixel_y=0, pixel_x=0, length_err cleared. The next frame_end produces frame_done one cycle later.
5. reset_n low for 1 cycle mid-line (count=3). Expect:
   - All outputs 0 immediately.
   - After release, the next beat is treated as count 0 with pixel_x=0.
   - No spurious pixel_enable.
6. PIXEL_WIDTH=8 build with the stimulus from scenario 1. Expect pixel = {11, 22, 33, 44}.
